ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: AHB-Lite master that turns a simple command handshake into
// a single transfer or a 4-beat incrementing burst on the bus.
// Build option AHB_MST_ERR_ABORT_EN: when defined, an ERROR response cancels
// the remaining beats of the burst; otherwise the burst resumes at the next beat.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | bus idle, cmd_ready high, waiting for a command
// S_ADDR      | a beat is in address phase (previous beat may be in data phase)
// S_DATA_LAST | final beat in data phase, bus driven IDLE
// S_ERR2      | second cycle of an ERROR response, bus driven IDLE
module ahb_lite_master #(
    parameter int ADDR_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic              cmd_incr4,
    input  logic [127:0]      cmd_wdata,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              rd_err,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;
    localparam logic [2:0] BU_INCR4  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR      = 2'd1,
        S_DATA_LAST = 2'd2,
        S_ERR2      = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_hsel;
    logic [ADDR_W-1:0] r_haddr;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [2:0]        r_hburst;
    logic [31:0]       r_hwdata;
    logic [127:0]      r_wdata;
    logic [1:0]        r_beat;
    logic [1:0]        r_last_beat;
    logic              r_dp_valid;
    logic              r_err;
    logic              r_rd_valid;
    logic [31:0]       r_rd_data;
    logic              r_rd_err;
    logic              r_cmd_done;
    logic              r_cmd_err;

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_next_nonseq;
    logic              w_err1;
    logic              w_last;
    logic [31:0]       w_wbeat;
    logic [9:0]        w_cstep;
    logic [9:0]        w_ca0;
    logic [9:0]        w_ca1;
    logic [9:0]        w_ca2;
    logic [9:0]        w_ca3;
    logic              w_bnd;

    assign w_step        = ADDR_W'(1) << r_hsize;
    assign w_next_addr   = r_haddr + w_step;
    assign w_next_nonseq = (w_next_addr[9:0] == 10'd0);
    // First cycle of a two-cycle ERROR response for the beat in data phase.
    assign w_err1        = r_dp_valid & hresp & ~hready;
    assign w_last        = (r_beat == r_last_beat);
    assign w_wbeat       = r_wdata[{r_beat, 5'b00000} +: 32];

    // Any INCR4 beat landing on a 1KB boundary downgrades the burst to INCR.
    assign w_cstep = 10'(1) << cmd_size;
    assign w_ca0   = cmd_addr[9:0];
    assign w_ca1   = w_ca0 + w_cstep;
    assign w_ca2   = w_ca1 + w_cstep;
    assign w_ca3   = w_ca2 + w_cstep;
    assign w_bnd   = (w_ca0 == 10'd0) | (w_ca1 == 10'd0) | (w_ca2 == 10'd0) | (w_ca3 == 10'd0);

    // The slave ignores the pending address phase during ERROR cycle 1, so
    // htrans is forced to IDLE in that very cycle.
    assign htrans    = w_err1 ? TR_IDLE : r_htrans;
    assign hsel      = r_hsel;
    assign haddr     = r_haddr;
    assign hwrite    = r_hwrite;
    assign hsize     = r_hsize;
    assign hburst    = r_hburst;
    assign hprot     = 4'b0011;
    assign hwdata    = r_hwdata;
    assign cmd_ready = r_cmd_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_err    = r_rd_err;
    assign cmd_done  = r_cmd_done;
    assign cmd_err   = r_cmd_err;

    // Command sequencing, bus address/data phases and completion pulses.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_hsel      <= 1'b0;
            r_haddr     <= '0;
            r_htrans    <= TR_IDLE;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'b010;
            r_hburst    <= BU_SINGLE;
            r_hwdata    <= '0;
            r_wdata     <= '0;
            r_beat      <= 2'd0;
            r_last_beat <= 2'd0;
            r_dp_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_err    <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_cmd_done <= 1'b0;
            r_cmd_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_hsel      <= 1'b1;
                        r_haddr     <= cmd_addr;
                        r_htrans    <= TR_NONSEQ;
                        r_hwrite    <= cmd_write;
                        r_hsize     <= cmd_size;
                        r_hburst    <= !cmd_incr4 ? BU_SINGLE : (w_bnd ? BU_INCR : BU_INCR4);
                        r_wdata     <= cmd_wdata;
                        r_beat      <= 2'd0;
                        r_last_beat <= cmd_incr4 ? 2'd3 : 2'd0;
                        r_dp_valid  <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_err1) begin
                        r_err    <= 1'b1;
                        r_htrans <= TR_IDLE;
                        r_state  <= S_ERR2;
                    end else if (hready) begin
                        if (r_dp_valid && !r_hwrite) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= hrdata;
                        end
                        r_dp_valid <= 1'b1;
                        if (r_hwrite) begin
                            r_hwdata <= w_wbeat;
                        end
                        if (w_last) begin
                            r_htrans <= TR_IDLE;
                            r_hsel   <= 1'b0;
                            r_state  <= S_DATA_LAST;
                        end else begin
                            r_beat   <= r_beat + 2'd1;
                            r_haddr  <= w_next_addr;
                            r_htrans <= w_next_nonseq ? TR_NONSEQ : TR_SEQ;
                        end
                    end
                end
                S_DATA_LAST: begin
                    if (w_err1) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR2;
                    end else if (hready) begin
                        if (!r_hwrite) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= hrdata;
                        end
                        r_dp_valid  <= 1'b0;
                        r_cmd_done  <= 1'b1;
                        r_cmd_err   <= r_err;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_ERR2: begin
                    if (hready) begin
                        if (!r_hwrite) begin
                            r_rd_valid <= 1'b1;
                            r_rd_err   <= 1'b1;
                            r_rd_data  <= '0;
                        end
                        r_dp_valid <= 1'b0;
`ifdef AHB_MST_ERR_ABORT_EN
                        r_hsel      <= 1'b0;
                        r_htrans    <= TR_IDLE;
                        r_cmd_done  <= 1'b1;
                        r_cmd_err   <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
`else
                        // hsel still high means the cancelled beat is pending.
                        if (r_hsel) begin
                            r_htrans <= TR_NONSEQ;
                            r_state  <= S_ADDR;
                        end else begin
                            r_htrans    <= TR_IDLE;
                            r_cmd_done  <= 1'b1;
                            r_cmd_err   <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: randomized bench with a behavioural AHB slave and a
// transaction-level model of the expected beats, read returns and completion.
module tb_ahb_lite_master;

    logic          hclk = 1'b0;
    logic          hreset = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_incr4;
    logic [31:0]   cmd_addr;
    logic [2:0]    cmd_size;
    logic [127:0]  cmd_wdata;
    logic          rd_valid, rd_err, cmd_done, cmd_err;
    logic [31:0]   rd_data;
    logic          hsel, hwrite, hready, hresp;
    logic [31:0]   haddr, hwdata, hrdata;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;

    ahb_lite_master #(.ADDR_W(32)) dut (
        .hclk(hclk), .hreset(hreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_incr4(cmd_incr4), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .cmd_done(cmd_done), .cmd_err(cmd_err),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct { logic [31:0] addr; logic [1:0] trans; logic [2:0] burst; } beat_t;
    typedef struct { logic [31:0] d; logic e; } rd_t;

    int n_vec = 0;
    int n_bad = 0;

    beat_t        exp_beats[$];
    rd_t          rd_q[$];
    int           p_wait[4];
    logic [31:0]  p_rdata[4];
    int           p_err;
    logic [127:0] c_wdata;
    logic         c_write;
    logic [2:0]   c_size;
    int           c_nbeats, c_nrd;

    bit           s_dp, s_write, s_err;
    int           s_wait, s_stage;
    logic [31:0]  s_rdata, s_wexp;
    int           beats_seen;

    bit           acc_seen, acc_prev, done_seen, cmd_pending, hold_chk;
    logic         done_err;
    int           cyc, acc_cyc, last_addr_cyc, done_cyc, rd_cnt;
    logic [31:0]  hold_addr;
    logic [1:0]   hold_trans;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected beats derived from the command: address stepping, 1KB rule, error handling.
    task automatic build_expect(input logic [31:0] a, input logic [2:0] sz, input bit inc, input bit wr);
        int n, last;
        bit bnd;
        logic [31:0] ai;
        logic [2:0] bu;
        n = inc ? 4 : 1;
        bnd = 0;
        for (int i = 0; i < n; i++) begin
            ai = a + (32'(i) << sz);
            if (inc && ai[9:0] == 10'd0) bnd = 1;
        end
        bu = !inc ? 3'b000 : (bnd ? 3'b001 : 3'b011);
        last = n - 1;
`ifdef AHB_MST_ERR_ABORT_EN
        if (p_err >= 0) last = p_err;
`endif
        exp_beats.delete();
        rd_q.delete();
        for (int i = 0; i <= last; i++) begin
            beat_t b;
            ai = a + (32'(i) << sz);
            b.addr  = ai;
            b.burst = bu;
            b.trans = (i == 0 || ai[9:0] == 10'd0 || (p_err >= 0 && i == p_err + 1)) ? 2'b10 : 2'b11;
            exp_beats.push_back(b);
        end
        c_nbeats = last + 1;
        c_nrd    = wr ? 0 : last + 1;
    endtask

    task automatic slave_drive();
        hrdata = $urandom;
        hresp  = 1'b0;
        hready = 1'b1;
        if (s_dp) begin
            if (s_wait > 0) hready = 1'b0;
            else if (s_err) begin
                hresp  = 1'b1;
                hready = (s_stage == 1);
            end else if (!s_write) hrdata = s_rdata;
        end
    endtask

    task automatic monitor();
        bit in_err1, in_err2;
        in_err1 = s_dp && s_wait == 0 && s_err && s_stage == 0;
        in_err2 = s_dp && s_wait == 0 && s_err && s_stage == 1;
        if (rd_valid) begin
            if (rd_q.size() == 0) check_val("rd_unexpected", rd_valid, 0);
            else begin
                rd_t e;
                e = rd_q.pop_front();
                check_val("rd_data", rd_data, e.d);
                check_val("rd_err", rd_err, e.e);
            end
            rd_cnt++;
        end
        if (cmd_done) begin
            done_seen = 1;
            done_cyc  = cyc;
            done_err  = cmd_err;
            check_val("ready_at_done", cmd_ready, 1);
        end
        if (acc_prev) check_val("ready_after_acc", cmd_ready, 0);
        acc_prev = 0;
        if (cmd_valid && cmd_ready) begin
            acc_seen = 1;
            acc_cyc  = cyc;
            acc_prev = 1;
        end
        if (hold_chk) begin
            check_val("haddr_hold", haddr, hold_addr);
            if (!in_err1) check_val("htrans_hold", htrans, hold_trans);
        end
        if (in_err1) check_val("htrans_err1", htrans, 2'b00);
        if (s_dp && s_write && !in_err1 && !in_err2) check_val("hwdata", hwdata, s_wexp);
        if (hready) begin
            if (s_dp && !s_write) begin
                if (in_err2) rd_q.push_back('{32'h0, 1'b1});
                else rd_q.push_back('{s_rdata, 1'b0});
            end
            s_dp = 0;
            if (hsel && htrans[1]) begin
                if (exp_beats.size() == 0) check_val("beat_unexpected", htrans, 0);
                else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check_val("haddr", haddr, b.addr);
                    check_val("htrans", htrans, b.trans);
                    check_val("hburst", hburst, b.burst);
                    check_val("hwrite", hwrite, c_write);
                    check_val("hsize", hsize, c_size);
                    check_val("hprot", hprot, 4'b0011);
                end
                if (beats_seen == 0) check_val("first_addr_lat", cyc - acc_cyc, 1);
                last_addr_cyc = cyc;
                s_dp    = 1;
                s_write = hwrite;
                s_wait  = p_wait[beats_seen & 3];
                s_err   = (beats_seen == p_err);
                s_stage = 0;
                s_rdata = p_rdata[beats_seen & 3];
                s_wexp  = c_wdata[32*(beats_seen & 3) +: 32];
                beats_seen++;
            end
        end else if (s_dp) begin
            if (s_wait > 0) s_wait--;
            else if (s_err) s_stage = 1;
        end
        hold_chk   = !hready && hsel && htrans[1];
        hold_addr  = haddr;
        hold_trans = htrans;
        cyc++;
    endtask

    task automatic step();
        @(negedge hclk);
        if (acc_seen) cmd_valid = 1'b0;
        if (cmd_pending) begin
            cmd_valid   = 1'b1;
            cmd_pending = 0;
        end
        slave_drive();
        #1;
        monitor();
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [2:0] sz, input bit inc,
                             input bit wr, input logic [127:0] wd);
        build_expect(a, sz, inc, wr);
        c_wdata = wd; c_write = wr; c_size = sz;
        beats_seen = 0; rd_cnt = 0;
        acc_seen = 0; done_seen = 0;
        cmd_addr = a; cmd_size = sz; cmd_incr4 = inc; cmd_write = wr; cmd_wdata = wd;
        cmd_pending = 1;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [2:0] sz, input bit inc,
                           input bit wr, input logic [127:0] wd);
        int k;
        start_cmd(a, sz, inc, wr, wd);
        k = 0;
        while (!acc_seen && k < 40) begin step(); k++; end
        if (!acc_seen) check_val("accept_timeout", acc_seen, 1);
        k = 0;
        while (!done_seen && k < 300) begin step(); k++; end
        cmd_valid = 1'b0;
        check_val("done_seen", done_seen, 1);
        check_val("done_err", done_err, p_err >= 0);
        check_val("beat_count", beats_seen, c_nbeats);
        check_val("rd_count", rd_cnt, c_nrd);
        if (p_err < 0 && done_seen)
            check_val("done_latency", done_cyc - last_addr_cyc, 2 + p_wait[inc ? 3 : 0]);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) begin
            p_wait[i]  = 0;
            p_rdata[i] = $urandom;
        end
        p_err = -1;
    endtask

    initial begin
        logic [31:0]  a;
        logic [2:0]   sz;
        bit           inc, wr;
        logic [127:0] wd;
        int           k;

        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_incr4 = 0; cmd_wdata = 0;
        hready = 1; hresp = 0; hrdata = 0;
        s_dp = 0; cyc = 0; cmd_pending = 0; acc_seen = 0; acc_prev = 0; hold_chk = 0;
        c_wdata = 0; c_write = 0; c_size = 0; beats_seen = 0;
        clear_plan();

        #1 hreset = 1'b1;
        #2;
        check_val("rst_htrans", htrans, 2'b00);
        check_val("rst_hsel", hsel, 0);
        check_val("rst_haddr", haddr, 0);
        check_val("rst_hsize", hsize, 3'b010);
        check_val("rst_hburst", hburst, 3'b000);
        check_val("rst_hwdata", hwdata, 0);
        check_val("rst_ready", cmd_ready, 0);
        repeat (2) @(negedge hclk);
        #1;
        check_val("rst_ready_clk", cmd_ready, 0);
        check_val("rst_done", cmd_done, 0);
        check_val("rst_rdv", rd_valid, 0);
        hreset = 1'b0;
        check_val("ready_pre_edge", cmd_ready, 0);
        step();
        check_val("ready_post_edge", cmd_ready, 1);

        // single write
        clear_plan();
        run_cmd(32'h100, 3'd2, 0, 1, {96'h0, 32'hDEADBEEF});
        // INCR4 read returning 1..4
        clear_plan();
        for (int i = 0; i < 4; i++) p_rdata[i] = 32'(i + 1);
        run_cmd(32'h40, 3'd2, 1, 0, '0);
        // INCR4 write across 1KB boundary
        clear_plan();
        run_cmd(32'h3F8, 3'd2, 1, 1, {$urandom, $urandom, $urandom, $urandom});
        // INCR4 write with 3 wait states on beat 2
        clear_plan();
        p_wait[2] = 3;
        run_cmd(32'h200, 3'd2, 1, 1, {$urandom, $urandom, $urandom, $urandom});
        // INCR4 read with ERROR on beat 1
        clear_plan();
        p_err = 1;
        run_cmd(32'h80, 3'd2, 1, 0, '0);

        // randomized commands
        for (int t = 0; t < 80; t++) begin
            sz  = 3'($urandom_range(0, 2));
            inc = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 2) == 0)
                a = (a & 32'hFFFF_FC00) - (32'($urandom_range(0, 4)) << sz);
            a  = a & ~((32'd1 << sz) - 32'd1);
            wd = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                p_wait[i]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                p_rdata[i] = $urandom;
            end
            p_err = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, inc ? 3 : 0)) : -1;
            run_cmd(a, sz, inc, wr, wd);
            k = int'($urandom_range(0, 2));
            repeat (k) step();
        end

        // asynchronous reset in the middle of a burst
        clear_plan();
        start_cmd(32'h500, 3'd2, 1, 0, '0);
        k = 0;
        while (beats_seen < 3 && k < 40) begin step(); k++; end
        check_val("reached_beat3", beats_seen, 3);
        #2 hreset = 1'b1;
        #1;
        check_val("arst_htrans", htrans, 2'b00);
        check_val("arst_hsel", hsel, 0);
        exp_beats.delete();
        rd_q.delete();
        s_dp = 0;
        hold_chk = 0;
        done_seen = 0;
        repeat (3) step();
        check_val("arst_no_done", done_seen, 0);
        hreset = 1'b0;
        check_val("arst_ready_pre", cmd_ready, 0);
        step();
        check_val("arst_ready_post", cmd_ready, 1);
        check_val("arst_no_done2", done_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
